// File: rtl/pe_accum_ctrl.sv
// Job controller for a single PE: issues operand pairs, accumulates the
// PE's registered partial sums with saturation, and hands back the result.
module pe_accum_ctrl #(
  parameter int BITS_PSUM = 12,
  parameter int BITS_ACC  = 16,
  parameter int BITS_CNT  = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_Start,
  input  logic [BITS_CNT-1:0]         i_Len,
  input  logic                        i_SignI,
  input  logic                        i_SignW,
  output logic                        o_SignI,
  output logic                        o_SignW,
  input  logic                        i_FeedValid,
  output logic                        o_FeedReady,
  input  logic signed [BITS_PSUM-1:0] i_Psum,
  output logic signed [BITS_ACC-1:0]  o_Result,
  output logic                        o_ResultValid,
  input  logic                        i_ResultReady,
  output logic                        o_Busy,
  output logic                        o_Sat
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [BITS_CNT-1:0]        len_q;
  logic [BITS_CNT-1:0]        cnt;
  logic                       psum_vld;
  logic signed [BITS_ACC-1:0] acc;
  logic                       issue;
  logic                       start_ok;
  logic signed [BITS_ACC:0]   sum_wide;
  logic signed [BITS_ACC-1:0] sum_sat;
  logic                       clamp;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          start_ok  = 1'b1;
          state_nxt = (i_Len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issue = i_FeedValid;
        if (issue && (cnt == len_q - BITS_CNT'(1))) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    if (i_ResultReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One extra bit of headroom: the sum of two in-range values never wraps,
  // so disagreement of the top two bits flags overflow and its direction.
  always_comb begin
    sum_wide = (BITS_ACC+1)'(acc) + (BITS_ACC+1)'(i_Psum);
    clamp    = sum_wide[BITS_ACC] != sum_wide[BITS_ACC-1];
    if (!clamp)
      sum_sat = sum_wide[BITS_ACC-1:0];
    else if (sum_wide[BITS_ACC])
      sum_sat = {1'b1, {(BITS_ACC-1){1'b0}}};
    else
      sum_sat = {1'b0, {(BITS_ACC-1){1'b1}}};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      psum_vld <= 1'b0;
      acc      <= '0;
      o_Sat    <= 1'b0;
      o_SignI  <= 1'b0;
      o_SignW  <= 1'b0;
    end else begin
      state    <= state_nxt;
      psum_vld <= issue;
      if (start_ok) begin
        len_q   <= i_Len;
        o_SignI <= i_SignI;
        o_SignW <= i_SignW;
        cnt     <= '0;
        acc     <= '0;
        o_Sat   <= 1'b0;
      end else begin
        if (issue) cnt <= cnt + BITS_CNT'(1);
        // psum_vld trails the issue by one edge, matching the PE output register
        if (psum_vld) begin
          acc <= sum_sat;
          if (clamp) o_Sat <= 1'b1;
        end
      end
    end
  end

  assign o_FeedReady   = (state == RUN);
  assign o_ResultValid = (state == DONE);
  assign o_Busy        = (state != IDLE);
  assign o_Result      = acc;

endmodule
